// File: rtl/ifetch_pc_unit.sv
// ifetch_pc_unit: owns the architectural PC, fetches the instruction at PC over
// a req/gnt/rvalid handshake, holds it for decode, then loads the next PC.
// Handles flush/redirect (including dropping an in-flight response), and halts
// with a sticky error on a misaligned PC load or a fetch timeout.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/addr         fetch request and address (addr == pc)
//   imem_gnt              request accepted
//   imem_rvalid/rdata     response valid and instruction word
//   inst_valid/inst       held instruction for decode
//   inst_ready            decode consumes inst
//   pc, pc4               current PC and pc + 4
//   npc_valid, npc        next PC from next-PC logic
//   flush, flush_pc       redirect request and target
//   err, err_code         sticky error (01 misaligned, 10 timeout)
module ifetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ALIGN = 2'b01;
  localparam logic [1:0] E_TMO   = 2'b10;

  logic [2:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_inst;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [CW-1:0] r_cnt;

  logic [2:0]    w_state_nxt;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   w_inst_nxt;
  logic          w_err_nxt;
  logic [1:0]    w_err_code_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_waiting;
  logic          w_timeout;

  // Decoded outputs straight from registered state
  assign imem_req   = (r_state == S_REQ);
  assign inst_valid = (r_state == S_HOLD);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign pc4        = r_pc + 32'd4;
  assign inst       = r_inst;
  assign err        = r_err;
  assign err_code   = r_err_code;

  // A response is outstanding in both WAIT and DROP; both share the timeout
  assign w_waiting = (r_state == S_WAIT) || (r_state == S_DROP);
  assign w_timeout = w_waiting && !imem_rvalid && (r_cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_inst     <= 32'd0;
      r_err      <= 1'b0;
      r_err_code <= E_NONE;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state logic: error halt > flush > normal flow
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_nxt     = r_inst;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;
    w_cnt_nxt      = r_cnt;

    // Keep counting while a response is outstanding, also across a flush
    if (w_waiting && !imem_rvalid) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end

    if (r_state == S_HALT) begin
      w_state_nxt = S_HALT;
    end else if (w_timeout) begin
      w_err_nxt      = 1'b1;
      w_err_code_nxt = E_TMO;
      w_state_nxt    = S_HALT;
    end else if (flush) begin
      if (flush_pc[1:0] != 2'b00) begin
        w_err_nxt      = 1'b1;
        w_err_code_nxt = E_ALIGN;
        w_state_nxt    = S_HALT;
      end else begin
        w_pc_nxt = flush_pc;
        case (r_state)
          S_REQ: begin
            // A granted request still owes a response that must be dropped
            if (imem_gnt) begin
              w_state_nxt = S_DROP;
              w_cnt_nxt   = '0;
            end
          end
          S_WAIT:  w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
          S_HOLD:  w_state_nxt = S_REQ;
          S_DROP:  w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
          default: w_state_nxt = S_HALT;
        endcase
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_gnt) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_inst_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready && npc_valid) begin
            if (npc[1:0] != 2'b00) begin
              w_err_nxt      = 1'b1;
              w_err_code_nxt = E_ALIGN;
              w_state_nxt    = S_HALT;
            end else begin
              w_pc_nxt    = npc;
              w_state_nxt = S_REQ;
            end
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// tb_ifetch_pc_unit: directed self-checking bench for ifetch_pc_unit.
module tb_ifetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        npc_valid;
  logic [31:0] npc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_pc_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .pc(pc), .pc4(pc4), .npc_valid(npc_valid), .npc(npc),
    .flush(flush), .flush_pc(flush_pc), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    inst_ready  = 1'b0;
    npc_valid   = 1'b0;
    npc         = 32'd0;
    flush       = 1'b0;
    flush_pc    = 32'd0;
  endtask

  // From S_REQ: grant, then respond with data; ends in S_HOLD
  task automatic fetch(input logic [31:0] data);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    idle_inputs();
  endtask

  // From S_HOLD: consume with the given next PC
  task automatic consume(input logic [31:0] target);
    inst_ready = 1'b1;
    npc_valid  = 1'b1;
    npc        = target;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ivalid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_pc4", pc4, 32'h4);

    // Basic fetch at 0
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_req", 32'(imem_req), 32'd0);
    check("wait_ivalid", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    idle_inputs();
    check("hold_ivalid", 32'(inst_valid), 32'd1);
    check("hold_inst", inst, 32'h0050_0093);

    // inst_ready without npc_valid does not consume
    inst_ready = 1'b1;
    tick();
    idle_inputs();
    check("noconsume_ivalid", 32'(inst_valid), 32'd1);
    check("noconsume_pc", pc, 32'h0);
    check("noconsume_inst", inst, 32'h0050_0093);

    consume(32'h4);
    check("seq_req", 32'(imem_req), 32'd1);
    check("seq_addr", imem_addr, 32'h4);
    check("seq_pc4", pc4, 32'h8);

    // Branch target from pc=0x10
    fetch(32'h0000_0013);
    consume(32'h10);
    fetch(32'h0000_0013);
    check("br_pc_before", pc, 32'h10);
    consume(32'h40);
    check("br_addr", imem_addr, 32'h40);

    // Flush in S_WAIT; stale response two cycles later is dropped
    imem_gnt = 1'b1;
    tick();
    idle_inputs();
    flush    = 1'b1;
    flush_pc = 32'h100;
    tick();
    idle_inputs();
    check("fw_req", 32'(imem_req), 32'd0);
    check("fw_pc", pc, 32'h100);
    tick();
    check("fw_ivalid1", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("fw_ivalid2", 32'(inst_valid), 32'd0);
    check("fw_req2", 32'(imem_req), 32'd1);
    check("fw_addr", imem_addr, 32'h100);

    // Flush coincident with grant
    imem_gnt = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h200;
    tick();
    idle_inputs();
    check("fg_req", 32'(imem_req), 32'd0);
    check("fg_pc", pc, 32'h200);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    tick();
    idle_inputs();
    check("fg_ivalid", 32'(inst_valid), 32'd0);
    check("fg_req2", 32'(imem_req), 32'd1);
    check("fg_addr", imem_addr, 32'h200);
    fetch(32'h1234_5678);
    check("fg_inst", inst, 32'h1234_5678);

    // Flush in S_HOLD beats a simultaneous consume
    inst_ready = 1'b1;
    npc_valid  = 1'b1;
    npc        = 32'h204;
    flush      = 1'b1;
    flush_pc   = 32'h300;
    tick();
    idle_inputs();
    check("fh_ivalid", 32'(inst_valid), 32'd0);
    check("fh_addr", imem_addr, 32'h300);

    // Misaligned npc on consume halts
    fetch(32'h0000_0013);
    consume(32'h42);
    check("mis_err", 32'(err), 32'd1);
    check("mis_code", 32'(err_code), 32'd1);
    check("mis_pc", pc, 32'h300);
    check("mis_req", 32'(imem_req), 32'd0);
    imem_gnt   = 1'b1;
    flush      = 1'b1;
    flush_pc   = 32'h400;
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_pc", pc, 32'h300);
    check("halt_code", 32'(err_code), 32'd1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_err", 32'(err), 32'd0);
    check("rst2_req", 32'(imem_req), 32'd1);
    check("rst2_addr", imem_addr, 32'h0);

    // Timeout: 16 cycles in S_WAIT without rvalid
    imem_gnt = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 15; i++) tick();
    check("tmo_pre_err", 32'(err), 32'd0);
    check("tmo_pre_req", 32'(imem_req), 32'd0);
    tick();
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_code", 32'(err_code), 32'd2);
    check("tmo_req", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst3_err", 32'(err), 32'd0);
    check("rst3_code", 32'(err_code), 32'd0);
    check("rst3_req", 32'(imem_req), 32'd1);
    check("rst3_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_pc_unit.md
Name: ifetch_pc_unit

Overview:
- Owns the architectural PC register and drives it to the next-PC logic.
- Fetches the instruction at PC from instruction memory over a request/grant/response handshake, holds it for decode, then loads the next PC returned by the next-PC logic.
- Supports a pipeline flush/redirect, including discarding an in-flight response.
- Detects misaligned targets and memory timeouts, then halts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for imem_rvalid after grant; must be ≥ 2.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- imem_req, output, 1, fetch request valid.
- imem_addr, output, 32, fetch address; equals pc.
- imem_gnt, input, 1, request accepted this cycle when imem_req=1.
- imem_rvalid, input, 1, read data valid; earliest 1 cycle after grant.
- imem_rdata, input, 32, instruction word.
- inst_valid, output, 1, inst holds a valid instruction for pc.
- inst_ready, input, 1, decode consumes inst this cycle.
- inst, output, 32, held instruction.
- pc, output, 32, current PC, fed to next-PC logic.
- pc4, output, 32, pc + 4, combinational, mod 2^32.
- npc_valid, input, 1, npc is valid for the held instruction.
- npc, input, 32, next PC from next-PC logic.
- flush, input, 1, redirect request.
- flush_pc, input, 32, redirect target.
- err, output, 1, sticky error flag.
- err_code, output, 2, error cause: 00 none, 01 misaligned target, 10 fetch timeout.

Behaviour:
- Reset (rst_n=0 at a clock edge): pc=RESET_PC, state=S_REQ, inst=0, inst_valid=0, err=0, err_code=00, timeout counter=0.
- imem_req is combinational and equals (state==S_REQ). inst_valid=(state==S_HOLD). imem_addr=pc.
- Priority: reset > error halt > flush > normal flow.
- S_REQ:
  - imem_gnt=1 → S_WAIT, clear counter.
  - imem_addr must stay stable until granted.
- S_WAIT:
  - imem_rvalid=1 → inst<=imem_rdata, go to S_HOLD.
  - Otherwise increment counter. When counter reaches TIMEOUT-1 without rvalid → err=1, err_code=10, go to S_HALT.
- S_HOLD:
  - When inst_ready=1 and npc_valid=1: pc<=npc, go to S_REQ.
  - inst_ready without npc_valid: stay in S_HOLD; no consume.
  - npc_valid without inst_ready: ignored.
- S_DROP:
  - Wait for imem_rvalid, discard the data, go to S_REQ.
  - Uses the same timeout counter and rule as S_WAIT.
- S_HALT:
  - imem_req=0, inst_valid=0; all inputs ignored until reset.
- Alignment:
  - Any pc load (npc or flush_pc) with target[1:0]≠00 → pc not updated, err=1, err_code=01, go to S_HALT.
- Flush (valid in all states except S_HALT), pc<=flush_pc, with next state by current state:
  - S_REQ with imem_gnt=1 the same cycle: request is counted as issued → S_DROP.
  - S_REQ without grant: stay in S_REQ with the new address.
  - S_WAIT without rvalid: → S_DROP.
  - S_WAIT with rvalid the same cycle: data discarded → S_REQ.
  - S_HOLD: held instruction discarded, inst_valid=0 next cycle; flush takes priority over consume → S_REQ.
  - S_DROP: stay in S_DROP until the pending response arrives; if rvalid the same cycle → S_REQ.
- Minimum throughput: 3 cycles per instruction (grant, rvalid, consume).
- inst stays stable while in S_HOLD.
- err and err_code are sticky until reset. Reset mid-transaction abandons the outstanding response; the memory side must handle this.

Test Plan:
- Reset with RESET_PC=0: imem_req=1 and imem_addr=0 in the first cycle after reset release. Grant, then rvalid with rdata=32'h00500093 → inst_valid=1, inst=00500093. Consume with npc=4 → next imem_addr=4, pc4=8.
- Branch target: in S_HOLD at pc=0x10, npc_valid=1, inst_ready=1, npc=0x40 → imem_addr=0x40 the next cycle.
- Flush in S_WAIT with flush_pc=0x100: a stale rvalid (data 0xDEADBEEF) two cycles later is dropped, with inst_valid never asserted for it. Next request has imem_addr=0x100.
- Flush coincident with grant in S_REQ: unit enters S_DROP, discards the next rvalid, and re-requests at flush_pc.
- Misaligned npc=0x42 on consume: err=1, err_code=01, pc unchanged, imem_req stays 0 permanently.
- Timeout with TIMEOUT=16: grant and no rvalid for 16 cycles → err_code=10, halt. Asserting rst_n=0 then clears err and restarts the fetch at RESET_PC.
